// File: rtl/conv_window_feeder_pkg.sv
// Shared types and constants for the 3x3 window feeder.
package conv_window_feeder_pkg;

  typedef enum logic [1:0] {ACCEPT, LOAD, CALC, CAPT} state_t;

  localparam int TAP_COUNT = 9;
  localparam int WIN       = 3;
  localparam int PIX_W     = 8;

  // Tap index k -> (row, col) = (k/3, k%3) as a table.
  function automatic logic [1:0] tap_row(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: tap_row = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row = 2'd1;
      4'd6, 4'd7, 4'd8: tap_row = 2'd2;
      default:          tap_row = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: tap_col = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col = 2'd1;
      4'd2, 4'd5, 4'd8: tap_col = 2'd2;
      default:          tap_col = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_window_feeder_line_buffer.sv
// Two previous image rows; yields the 3-pixel column (oldest row first) at col.
module conv_line_buffer
  import conv_window_feeder_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int CW    = $clog2(IMG_W)
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [CW-1:0]                  col,
  input  logic [PIX_W-1:0]               pix,
  output logic [WIN-1:0][PIX_W-1:0]      column
);

  logic [PIX_W-1:0] line0 [IMG_W];
  logic [PIX_W-1:0] line1 [IMG_W];

  assign column[0] = line0[col];
  assign column[1] = line1[col];
  assign column[2] = pix;

  // Contents are never cleared: rows 0-1 of every frame refill them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line0[col] <= line1[col];
      line1[col] <= pix;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Raster pixel stream -> 3x3 window tap loads into the conv core -> result stream.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix,
  output logic             pix_ready,
  output logic             conv_data_in,
  output logic [1:0]       conv_row,
  output logic [1:0]       conv_col,
  output logic [PIX_W-1:0] conv_data,
  input  logic [PIX_W-1:0] conv_out,
  output logic             res_valid,
  output logic [PIX_W-1:0] res,
  output logic             res_last,
  input  logic             res_ready
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t                           state, state_nxt;
  logic [3:0]                       tap;
  logic [CW-1:0]                    col;
  logic [RW-1:0]                    row;
  logic                             last_q, capt_first;
  logic [PIX_W-1:0]                 res_q;
  logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win;
  logic [WIN-1:0][PIX_W-1:0]        column;
  logic                             accept, anchor;

  assign pix_ready = (state == ACCEPT) && !reset;
  assign accept    = pix_valid && pix_ready;
  assign anchor    = (row >= RW'(2)) && (col >= CW'(2));

  conv_line_buffer #(.IMG_W(IMG_W), .CW(CW)) u_lb (
    .clk    (clk),
    .wr_en  (accept),
    .col    (col),
    .pix    (pix),
    .column (column)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int m = 0; m < WIN; m++) begin
        win[m][0] <= win[m][1];
        win[m][1] <= win[m][2];
        win[m][2] <= column[m];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT: if (accept && anchor) state_nxt = LOAD;
      LOAD:   if (tap == 4'(TAP_COUNT - 1)) state_nxt = CALC;
      CALC:   state_nxt = CAPT;
      CAPT:   if (res_ready) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACCEPT;
      tap        <= '0;
      col        <= '0;
      row        <= '0;
      last_q     <= 1'b0;
      capt_first <= 1'b0;
      res_q      <= '0;
    end else begin
      state      <= state_nxt;
      tap        <= (state == LOAD && tap != 4'(TAP_COUNT - 1)) ? tap + 4'd1 : 4'd0;
      capt_first <= (state == CALC);
      if (capt_first) res_q <= conv_out;
      if (accept) begin
        last_q <= (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_comb begin
    conv_data_in = 1'b0;
    conv_row     = 2'd0;
    conv_col     = 2'd0;
    conv_data    = '0;
    if (state == LOAD) begin
      conv_data_in = 1'b1;
      conv_row     = tap_row(tap);
      conv_col     = tap_col(tap);
      conv_data    = win[tap_row(tap)][tap_col(tap)];
    end
  end

  // The core result lands in the first CAPT cycle; pass it through then, hold after.
  assign res_valid = (state == CAPT);
  assign res       = capt_first ? conv_out : res_q;
  assign res_last  = res_valid && last_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench: 8x8 frames through the feeder with a Sobel-Y core model.
module tb_conv_window_feeder;

  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_valid;
  logic [7:0] pix;
  logic       pix_ready;
  logic       conv_data_in;
  logic [1:0] conv_row, conv_col;
  logic [7:0] conv_data;
  logic [7:0] conv_out;
  logic       res_valid;
  logic [7:0] res;
  logic       res_last;
  logic       res_ready;

  int nvec = 0;
  int nerr = 0;
  int img [NPIX];
  logic [7:0] tap_q [3][3];
  int core_s;

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix          (pix),
    .pix_ready    (pix_ready),
    .conv_data_in (conv_data_in),
    .conv_row     (conv_row),
    .conv_col     (conv_col),
    .conv_data    (conv_data),
    .conv_out     (conv_out),
    .res_valid    (res_valid),
    .res          (res),
    .res_last     (res_last),
    .res_ready    (res_ready)
  );

  function automatic logic [7:0] clamp8(input int v);
    return (v < 0) ? 8'd0 : (v > 255) ? 8'd255 : 8'(v);
  endfunction

  // Core model: latches taps on write cycles, computes a registered Sobel-Y otherwise.
  always @(posedge clk) begin
    if (conv_data_in) tap_q[conv_row][conv_col] <= conv_data;
    else begin
      core_s = int'(tap_q[0][0]) + 2 * int'(tap_q[0][1]) + int'(tap_q[0][2])
             - int'(tap_q[2][0]) - 2 * int'(tap_q[2][1]) - int'(tap_q[2][2]);
      conv_out <= clamp8(core_s);
    end
  end

  function automatic int px(input int r, input int c);
    return img[r * IMG_W + c];
  endfunction

  function automatic logic [7:0] ref_res(input int idx);
    int r, c, s;
    r = idx / (IMG_W - 2) + 2;
    c = idx % (IMG_W - 2) + 2;
    s = px(r-2, c-2) + 2 * px(r-2, c-1) + px(r-2, c)
      - px(r, c-2) - 2 * px(r, c-1) - px(r, c);
    return clamp8(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0 const 10, 1: 200-20r, 2: 255-35r, 3: 10r, 4: 20c, 5: random
  task automatic fill(input int mode);
    for (int i = 0; i < NPIX; i++) begin
      case (mode)
        0: img[i] = 10;
        1: img[i] = 200 - 20 * (i / IMG_W);
        2: img[i] = 255 - 35 * (i / IMG_W);
        3: img[i] = 10 * (i / IMG_W);
        4: img[i] = 20 * (i % IMG_W);
        default: img[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic run_frame(input int hold, input int abort_at, input bit probe);
    int pi, ri, cyc, stall, t0, k;
    logic [7:0] held;
    pi = 0; ri = 0; cyc = 0; stall = hold; t0 = -100; held = '0;
    res_ready = 1'b1;
    while (ri < NRES && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (probe && cyc > t0 && cyc <= t0 + 11) begin
        k = cyc - t0 - 1;
        if (k < 9) begin
          chk("tap_in", conv_data_in, 1);
          chk("tap_row", conv_row, k / 3);
          chk("tap_col", conv_col, k % 3);
          chk("tap_data", conv_data, 200 - 20 * (k / 3));
        end else if (k == 9) begin
          chk("calc_in", conv_data_in, 0);
          chk("calc_rcd", {conv_row, conv_col, conv_data}, 0);
          chk("calc_rv", res_valid, 0);
        end else begin
          chk("latency_rv", res_valid, 1);
        end
      end
      if (abort_at > 0 && ri == abort_at - 1 && conv_data_in) begin
        reset = 1'b1;
        #1;
        chk("abort_pr", pix_ready, 0);
        chk("abort_rv", res_valid, 0);
        chk("abort_in", conv_data_in, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        pix_valid = 1'b0;
        return;
      end
      if (stall > 0 && res_valid) begin
        if (stall == hold) held = res;
        else chk("hold_res", res, held);
        chk("hold_rv", res_valid, 1);
        chk("hold_pr", pix_ready, 0);
        stall--;
        res_ready = 1'b0;
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        chk($sformatf("res[%0d]", ri), res, ref_res(ri));
        chk($sformatf("last[%0d]", ri), res_last, (ri == NRES - 1) ? 1 : 0);
        ri++;
      end
      pix_valid = (pi < NPIX);
      pix = (pi < NPIX) ? 8'(img[pi]) : 8'd0;
      if (pix_valid && pix_ready) begin
        if (probe && pi == 2 * IMG_W + 2) t0 = cyc;
        pi++;
      end
    end
    chk("frame_results", ri, NRES);
    chk("frame_pixels", pi, NPIX);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pix_valid = 1'b0;
    pix = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_data_in", conv_data_in, 0);
    chk("rst_res", res, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_rcd", {conv_row, conv_col, conv_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", pix_ready, 1);

    fill(0); run_frame(0, 0, 1'b0);
    fill(1); run_frame(0, 0, 1'b1);
    fill(2); run_frame(0, 0, 1'b0);
    fill(3); run_frame(0, 0, 1'b0);
    fill(4); run_frame(0, 0, 1'b0);
    fill(5); run_frame(20, 0, 1'b0);
    run_frame(0, 5, 1'b0);
    run_frame(0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Initiator side of the 3x3 convolution core's window-load interface.
- Accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 sliding window.
- For every valid output position it writes the 9 window taps into the core (load strobe, row, col, data), then issues one compute cycle, captures the core's clamped 8-bit result, and emits it on a valid/ready output stream.
- Sits between the image source and the convolution core in the filter datapath.

Parameters:
- IMG_W, 8, pixels per row (>=3).
- IMG_H, 8, rows per frame (>=3).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- pix_valid  input  1  source has a pixel.
- pix  input  8  pixel value, raster order, row 0 column 0 first.
- pix_ready  output  1  feeder accepts a pixel this cycle.
- conv_data_in  output  1  1 = tap write cycle, 0 = core computes.
- conv_row  output  2  window row of tap (0..2).
- conv_col  output  2  window column of tap (0..2).
- conv_data  output  8  tap value.
- conv_out  input  8  core result, valid the cycle after a compute cycle.
- res_valid  output  1  result available.
- res  output  8  result pixel.
- res_last  output  1  with res_valid, marks the final result of the frame.
- res_ready  input  1  sink accepts result.

Behaviour:
- Reset values: all outputs, state and counters go to 0 (state=ACCEPT, pix_ready=0, conv_data_in=0, res_valid=0). Line buffers and window are not cleared.
- Reset asserted mid-operation aborts the in-flight window and frame. After release, the next pixel is row 0 col 0.
- The core's own reset is not driven by this block; the top level handles it.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next pixel. col wraps to 0 and increments row. row wraps to 0 after the last pixel of the frame.

States:
- ACCEPT
  - pix_ready=1.
  - On pix_valid, the pixel is accepted:
    - window shifts left one column; new right column = {line0[col], line1[col], pix} for rows 0,1,2;
    - line0[col] <= line1[col]; line1[col] <= pix;
    - counters advance.
  - If the accepted pixel had row>=2 and col>=2, go to LOAD. Otherwise stay in ACCEPT.
  - Windows spanning a row boundary are never emitted, so stale columns need no flush.
- LOAD, 9 cycles
  - conv_data_in=1; taps issued in order (m,n) = (0,0),(0,1),…,(2,2); conv_row=m, conv_col=n, conv_data=window[m][n].
  - Row 0 is the oldest image row; column 0 is the leftmost.
  - pix_ready=0.
  - After tap (2,2), go to CALC.
- CALC, 1 cycle
  - conv_data_in=0; row/col/data held at 0. The core computes on this edge.
  - Next state: CAPT.
- CAPT
  - On entry, res <= conv_out and res_valid=1.
  - res_last=1 if the window was anchored at row IMG_H-1, col IMG_W-1.
  - res is held stable while res_ready=0.
  - On res_valid && res_ready, go to ACCEPT.
- Outside LOAD, conv_data_in=0. The core recomputes harmlessly; its output is ignored except in CAPT.
- Latency:
  - A qualifying pixel accepted at cycle t gives LOAD t+1..t+9, CALC t+10, res_valid at t+11.
  - Minimum period is 12 cycles per output once rows >=2.
  - Rows 0-1 and cols 0-1 are accepted at 1 pixel/cycle.
- Output count per frame: (IMG_W-2)*(IMG_H-2), in raster order of window anchor.
- Simultaneous events:
  - pix_valid during LOAD/CALC/CAPT is ignored (pix_ready=0). The source must hold it.
  - res_ready without res_valid has no effect.
- Widths:
  - counters are clog2(IMG_W) and clog2(IMG_H);
  - tap counter is 4 bits (0..8), mapped to m = k/3, n = k%3 via a constant lookup, not a divider.

Decomposition:
- Shared package: state encoding (ACCEPT, LOAD, CALC, CAPT), TAP_COUNT=9, WIN=3, PIX_W=8.
- One sub-module: conv_line_buffer. It holds two IMG_W x 8 register rows with a column read/shift-write port and returns the 3-entry column for the window.

Test Plan:
- Constant image, all pixels 10, 8x8 frame -> 36 results, all res=0, res_last only on the 36th.
- Vertical ramp pix = 200-20*row -> every res=160.
- Vertical ramp pix = 255-35*row -> every res=255 (raw 280 clamps).
- Increasing ramp pix = 10*row -> every res=0 (raw -80 clamps).
- Horizontal ramp pix = 20*col -> every res=0.
- Probe the load interface for the first window of the 200-20*row image: 9 cycles with data_in=1 and (row,col) sequence (0,0)..(2,2); data 200,200,200,180,180,180,160,160,160; then one data_in=0 cycle; res_valid exactly 11 cycles after the accepting edge of pixel (2,2).
- Hold res_ready=0 for 20 cycles on the first result -> res and res_valid stable, pix_ready=0, no pixel lost; the full 36-result sequence matches the reference model.
- Assert reset during LOAD of window 5, then replay the full frame -> outputs identical to a clean run, 36 results, res_last on the last.
